// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: bus-slave front end for a 32-bit byte-lane RAM.
// Handles one load/store at a time with valid/ready on both the request and
// response sides. Stores go to the RAM in their accept cycle. Loads return data
// one cycle after accept. A hold register keeps a stalled response stable.
module ram_bus_ctrl #(
    parameter int DP = 512,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [AW-1:0] req_addr_i,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_unsigned_i,
    input  logic [31:0]   req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_data_o,
    output logic [3:0]    ram_sel_o,
    output logic          ram_we_o,
    input  logic [31:0]   ram_data_i
);

    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

    localparam logic [AW-1:0] DP_W = AW'(DP);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [31:0]   hold_q;
    logic          err_q;
    logic          load_q;
    logic          uns_q;
    logic [1:0]    size_q;
    logic [1:0]    off_q;

    logic          accept;
    logic          req_err;
    logic          store_go;
    logic [AW-1:0] word_addr;
    logic [3:0]    sel_base;
    logic [31:0]   wdata_rep;
    logic [31:0]   lane_shift;
    logic [31:0]   rdata_fmt;

    assign word_addr = {2'b00, req_addr_i[AW-1:2]};

    // A new request may enter when idle, or when the current response is being
    // consumed this very cycle; never while reset is asserted.
    assign req_ready_o = ~rst & ((state_q == IDLE) | rsp_ready_i);
    assign accept      = req_valid_i & req_ready_o;
    assign store_go    = accept & req_we_i & ~req_err;

    // Illegal size, misalignment, or word index beyond the RAM depth.
    always_comb begin
        req_err = 1'b0;
        if (req_size_i == 2'd3)                              req_err = 1'b1;
        if ((req_size_i == 2'd1) && req_addr_i[0])           req_err = 1'b1;
        if ((req_size_i == 2'd2) && (req_addr_i[1:0] != 2'b00)) req_err = 1'b1;
        if (word_addr >= DP_W)                               req_err = 1'b1;
    end

    // Lane mask and lane-replicated store data by access size.
    always_comb begin
        sel_base  = 4'b0001;
        wdata_rep = {4{req_wdata_i[7:0]}};
        case (req_size_i)
            2'd1: begin
                sel_base  = 4'b0011;
                wdata_rep = {2{req_wdata_i[15:0]}};
            end
            2'd2: begin
                sel_base  = 4'b1111;
                wdata_rep = req_wdata_i;
            end
            default: ;
        endcase
    end

    assign ram_we_o   = store_go;
    assign ram_sel_o  = store_go ? (sel_base << req_addr_i[1:0]) : 4'b0000;
    assign ram_data_o = store_go ? wdata_rep : 32'h0;
    // The accept cycle presents the new address directly so the RAM samples it
    // at once; afterwards the registered copy keeps it stable.
    assign ram_addr_o = accept ? word_addr : addr_q;

    // Extract the addressed lanes of the returned word and extend them.
    always_comb begin
        lane_shift = ram_data_i >> {off_q, 3'b000};
        case (size_q)
            2'd0:    rdata_fmt = uns_q ? {24'h0, lane_shift[7:0]}
                                       : {{24{lane_shift[7]}}, lane_shift[7:0]};
            2'd1:    rdata_fmt = uns_q ? {16'h0, lane_shift[15:0]}
                                       : {{16{lane_shift[15]}}, lane_shift[15:0]};
            default: rdata_fmt = lane_shift;
        endcase
        if (!load_q) rdata_fmt = 32'h0;
    end

    assign rsp_valid_o = (state_q != IDLE);
    assign rsp_err_o   = err_q;
    assign rsp_rdata_o = (state_q == HOLD) ? hold_q :
                         (state_q == RESP) ? rdata_fmt : 32'h0;

    // Next-state: a stalled response parks in HOLD; a consumed one either
    // chains straight into the next request or returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RESP;
            RESP, HOLD: begin
                if (rsp_ready_i) state_d = accept ? RESP : IDLE;
                else             state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request attributes and the stalled-response hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            hold_q  <= 32'h0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            off_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == RESP) hold_q <= rdata_fmt;
            if (accept) begin
                addr_q <= word_addr;
                err_q  <= req_err;
                load_q <= ~req_we_i & ~req_err;
                uns_q  <= req_unsigned_i;
                size_q <= req_size_i;
                off_q  <= req_addr_i[1:0];
            end else if (state_d == IDLE) begin
                err_q  <= 1'b0;
                load_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Testbench for ram_bus_ctrl: a behavioural byte-lane RAM with a registered
// read, a table of single transactions, and hand-written sequences for stalls,
// back-to-back traffic and reset in the middle of a transaction.
module tb_ram_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [3:0]  ram_sel_o;
    logic        ram_we_o;
    logic [31:0] ram_data_i;

    int checks   = 0;
    int failures = 0;

    ram_bus_ctrl #(.DP(512), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_sel_o(ram_sel_o), .ram_we_o(ram_we_o), .ram_data_i(ram_data_i)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: byte-lane writes, read data one cycle after the address.
    logic [31:0] mem [0:511];
    logic [31:0] ram_q;
    logic        tb_init;
    logic        ovr;
    logic [31:0] junk;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
            mem[1] <= 32'hCAFEF00D;
            ram_q  <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_we_o && ram_sel_o[b])
                    mem[ram_addr_o[8:0]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
            ram_q <= mem[ram_addr_o[8:0]];
        end
    end

    assign ram_data_i = ovr ? junk : ram_q;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
    endtask

    // One isolated transaction with the response consumed immediately.
    task automatic do_txn(input int idx, input vec_t v);
        logic exp_we;
        exp_we = v.we & ~v.exp_err;
        @(negedge clk);
        drive(v.we, v.size, v.uns, v.addr, v.wdata);
        rsp_ready_i = 1'b1;
        #1;
        chk("req_ready", {31'b0, req_ready_o}, 32'd1);
        chk("ram_we", {31'b0, ram_we_o}, {31'b0, exp_we});
        chk("ram_sel", {28'b0, ram_sel_o}, exp_we ? {28'b0, v.exp_sel} : 32'h0);
        chk("ram_data", ram_data_o, exp_we ? v.exp_wdata : 32'h0);
        if (!v.exp_err) chk("ram_addr", ram_addr_o, v.addr >> 2);
        @(posedge clk);
        #1;
        chk("rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, v.exp_err});
        chk("rsp_rdata", rsp_rdata_o, v.exp_rdata);
        $display("txn %0d we=%0b size=%0d uns=%0b addr=%h rdata=%h err=%0b",
                 idx, v.we, v.size, v.uns, v.addr, rsp_rdata_o, rsp_err_o);
        @(negedge clk);
        req_valid_i = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        //          we    size  uns   addr          wdata         err   sel      wdata_out     rdata
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 4'b0000, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h123456A5, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,        1'b0, 4'b0000, 32'h0,        32'hFFFFFFA5};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h000000A5};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0011, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0012, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0800, 32'h55555555, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 4'b0000, 32'h0,        32'hA5ADBEEF};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0016, 32'hFFFF8001, 1'b0, 4'b1100, 32'h80018001, 32'h0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h0000_0016, 32'h0,        1'b0, 4'b0000, 32'h0,        32'hFFFF8001};
        vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h0000_0016, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h00008001};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_0014, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h80010000};
        vecs[13] = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[14] = '{1'b0, 2'd0, 1'b0, 32'h0000_0011, 32'h0,        1'b0, 4'b0000, 32'h0,        32'hFFFFFFBE};
        vecs[15] = '{1'b1, 2'd0, 1'b0, 32'h0000_07FF, 32'h0000007C, 1'b0, 4'b1000, 32'h7C7C7C7C, 32'h0};
        vecs[16] = '{1'b0, 2'd0, 1'b1, 32'h0000_07FF, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0000007C};
        vecs[17] = '{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0};

        // Reset with a store request pending: nothing may be written or accepted.
        rst = 1'b1; tb_init = 1'b1; ovr = 1'b0; junk = 32'h0; rsp_ready_i = 1'b1;
        drive(1'b1, 2'd2, 1'b0, 32'h10, 32'h0BADF00D);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_we", {31'b0, ram_we_o}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready_o}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err_o}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("rst_ram_addr", ram_addr_o, 32'h0);
        rst = 1'b0; tb_init = 1'b0; req_valid_i = 1'b0;
        #1;
        chk("idle_req_ready", {31'b0, req_ready_o}, 32'd1);
        @(posedge clk);

        for (int i = 0; i < 18; i++) do_txn(i, vecs[i]);

        // Stalled load: response must hold while RAM data changes underneath.
        @(negedge clk);
        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        rsp_ready_i = 1'b0;
        @(negedge clk);
        drive(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        #1;
        chk("stall_resp_valid", {31'b0, rsp_valid_o}, 32'd1);
        chk("stall_resp_rdata", rsp_rdata_o, 32'hA5ADBEEF);
        chk("stall_resp_ready", {31'b0, req_ready_o}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ovr  = 1'b1;
            junk = 32'h13572468 ^ (32'h01010101 << c);
            #1;
            chk("hold_rdata", rsp_rdata_o, 32'hA5ADBEEF);
            chk("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
            chk("hold_req_ready", {31'b0, req_ready_o}, 32'd0);
            chk("hold_ram_we", {31'b0, ram_we_o}, 32'd0);
            $display("hold cycle %0d rdata=%h", c, rsp_rdata_o);
        end
        @(negedge clk);
        ovr = 1'b0;
        rsp_ready_i = 1'b1;
        #1;
        chk("release_req_ready", {31'b0, req_ready_o}, 32'd1);
        chk("release_ram_addr", ram_addr_o, 32'h5);
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("after_hold_valid", {31'b0, rsp_valid_o}, 32'd1);
        chk("after_hold_rdata", rsp_rdata_o, 32'h80010000);
        $display("stalled load released, next rdata=%h", rsp_rdata_o);
        @(negedge clk);
        chk("after_hold_idle", {31'b0, rsp_valid_o}, 32'd0);

        // Back-to-back: store @0, load @0, load @4 on consecutive cycles.
        @(negedge clk);
        drive(1'b1, 2'd2, 1'b0, 32'h0, 32'h11223344);
        #1;
        chk("b2b_st_ready", {31'b0, req_ready_o}, 32'd1);
        chk("b2b_st_we", {31'b0, ram_we_o}, 32'd1);
        @(negedge clk);
        drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        #1;
        chk("b2b_ld0_ready", {31'b0, req_ready_o}, 32'd1);
        chk("b2b_st_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        chk("b2b_st_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("b2b_ld0_we", {31'b0, ram_we_o}, 32'd0);
        $display("b2b store rsp rdata=%h err=%0b", rsp_rdata_o, rsp_err_o);
        @(negedge clk);
        drive(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
        #1;
        chk("b2b_ld4_ready", {31'b0, req_ready_o}, 32'd1);
        chk("b2b_ld0_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        chk("b2b_ld0_rsp_rdata", rsp_rdata_o, 32'h11223344);
        $display("b2b load@0 rsp rdata=%h", rsp_rdata_o);
        @(negedge clk);
        req_valid_i = 1'b0;
        #1;
        chk("b2b_ld4_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        chk("b2b_ld4_rsp_rdata", rsp_rdata_o, 32'hCAFEF00D);
        $display("b2b load@4 rsp rdata=%h", rsp_rdata_o);
        @(negedge clk);
        chk("b2b_idle", {31'b0, rsp_valid_o}, 32'd0);

        // Reset the cycle after a load accept, with a store request pending.
        @(negedge clk);
        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        drive(1'b1, 2'd2, 1'b0, 32'h20, 32'hBAD0BAD0);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", {31'b0, ram_we_o}, 32'd0);
        chk("mid_rst_sel", {28'b0, ram_sel_o}, 32'h0);
        chk("mid_rst_ready", {31'b0, req_ready_o}, 32'd0);
        @(negedge clk);
        chk("mid_rst_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("mid_rst_we2", {31'b0, ram_we_o}, 32'd0);
        chk("mid_rst_addr", ram_addr_o, 32'h0);
        rst = 1'b0;
        req_valid_i = 1'b0;
        #1;
        chk("post_rst_valid", {31'b0, rsp_valid_o}, 32'd0);
        $display("reset mid-load: rsp_valid=%0b", rsp_valid_o);
        @(posedge clk);
        do_txn(18, '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
